// File: rtl/sample_iterator.sv
// Sample iterator: accepts one triangle plus its bounding box, then walks every
// subsample position in the box in raster order, emitting one sample per clock.
module sample_iterator #(
    parameter int unsigned SIGFIG = 24,
    parameter int unsigned RADIX  = 10,
    parameter int unsigned VERTS  = 3,
    parameter int unsigned AXIS   = 3,
    parameter int unsigned COLORS = 3
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   tri_R13S,
    input  logic [COLORS-1:0][SIGFIG-1:0]            color_R13U,
    input  logic [1:0][1:0][SIGFIG-1:0]              box_R13S,
    input  logic                                     validTri_R13H,
    input  logic [3:0]                               subSample_RnnnnU,
    output logic                                     halt_RnnnnL,
    output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   tri_R14S,
    output logic [COLORS-1:0][SIGFIG-1:0]            color_R14U,
    output logic [1:0][SIGFIG-1:0]                   sample_R14S,
    output logic                                     validSamp_R14H
);

    typedef enum logic [0:0] {WAIT, TEST} state_t;
    typedef logic signed [SIGFIG:0] ext_t;

    state_t                                   state_q, state_d;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   tri_q, tri_d;
    logic [COLORS-1:0][SIGFIG-1:0]            color_q, color_d;
    logic signed [SIGFIG-1:0]                 ll_x_q, ll_x_d, ll_y_q, ll_y_d;
    logic signed [SIGFIG-1:0]                 ur_x_q, ur_x_d, ur_y_q, ur_y_d;
    logic signed [SIGFIG-1:0]                 x_q, x_d, y_q, y_d;
    logic [SIGFIG-1:0]                        step_q, step_d, step_sel;
    logic                                     valid_q, valid_d;

    ext_t nx, ny, step_ext;
    logic inverted;

    // Subsample step decode; anything not one-hot falls back to a full pixel.
    always_comb begin
        case (subSample_RnnnnU)
            4'b1000: step_sel = SIGFIG'(1) << RADIX;
            4'b0100: step_sel = SIGFIG'(1) << (RADIX - 1);
            4'b0010: step_sel = SIGFIG'(1) << (RADIX - 2);
            4'b0001: step_sel = SIGFIG'(1) << (RADIX - 3);
            default: step_sel = SIGFIG'(1) << RADIX;
        endcase
    end

    // One extra bit so stepping past the upper-right corner cannot wrap.
    assign step_ext = {1'b0, step_q};
    assign nx       = ext_t'({x_q[SIGFIG-1], x_q}) + step_ext;
    assign ny       = ext_t'({y_q[SIGFIG-1], y_q}) + step_ext;
    assign inverted = (ur_x_q < ll_x_q) || (ur_y_q < ll_y_q);

    always_comb begin
        state_d = state_q;
        tri_d   = tri_q;
        color_d = color_q;
        ll_x_d  = ll_x_q;
        ll_y_d  = ll_y_q;
        ur_x_d  = ur_x_q;
        ur_y_d  = ur_y_q;
        step_d  = step_q;
        x_d     = x_q;
        y_d     = y_q;
        valid_d = 1'b0;
        case (state_q)
            WAIT: begin
                if (validTri_R13H) begin
                    tri_d   = tri_R13S;
                    color_d = color_R13U;
                    ll_x_d  = box_R13S[0][0];
                    ll_y_d  = box_R13S[0][1];
                    ur_x_d  = box_R13S[1][0];
                    ur_y_d  = box_R13S[1][1];
                    step_d  = step_sel;
                    x_d     = box_R13S[0][0];
                    y_d     = box_R13S[0][1];
                    valid_d = 1'b1;
                    state_d = TEST;
                end
            end
            TEST: begin
                // An inverted box presents only its lower-left corner.
                if (!inverted && nx <= ext_t'({ur_x_q[SIGFIG-1], ur_x_q})) begin
                    x_d     = nx[SIGFIG-1:0];
                    valid_d = 1'b1;
                end else if (!inverted && ny <= ext_t'({ur_y_q[SIGFIG-1], ur_y_q})) begin
                    x_d     = ll_x_q;
                    y_d     = ny[SIGFIG-1:0];
                    valid_d = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            default: state_d = WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= WAIT;
            tri_q   <= '0;
            color_q <= '0;
            ll_x_q  <= '0;
            ll_y_q  <= '0;
            ur_x_q  <= '0;
            ur_y_q  <= '0;
            step_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tri_q   <= tri_d;
            color_q <= color_d;
            ll_x_q  <= ll_x_d;
            ll_y_q  <= ll_y_d;
            ur_x_q  <= ur_x_d;
            ur_y_q  <= ur_y_d;
            step_q  <= step_d;
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign halt_RnnnnL    = (state_q == WAIT);
    assign tri_R14S       = tri_q;
    assign color_R14U     = color_q;
    assign sample_R14S    = {y_q, x_q};
    assign validSamp_R14H = valid_q;

endmodule

// File: tb/tb_sample_iterator.sv
// Directed bench for sample_iterator: raster walks, step sizes, signed and
// degenerate boxes, back-to-back triangles, and reset mid-walk.
module tb_sample_iterator;

    typedef logic [2:0][2:0][23:0] tri_t;

    logic                  clk;
    logic                  rst;
    tri_t                  tri_in;
    logic [2:0][23:0]      color_in;
    logic [1:0][1:0][23:0] box_in;
    logic                  valid_in;
    logic [3:0]            sub_in;
    logic                  halt;
    tri_t                  tri_out;
    logic [2:0][23:0]      color_out;
    logic [1:0][23:0]      sample;
    logic                  valid_out;

    int tests;
    int fails;

    tri_t ta, tb, tc, td;

    sample_iterator dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_in),
        .color_R13U       (color_in),
        .box_R13S         (box_in),
        .validTri_R13H    (valid_in),
        .subSample_RnnnnU (sub_in),
        .halt_RnnnnL      (halt),
        .tri_R14S         (tri_out),
        .color_R14U       (color_out),
        .sample_R14S      (sample),
        .validSamp_R14H   (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input tri_t t, input int llx, input int lly, input int urx,
                        input int ury, input logic [3:0] sub, input bit hold);
        tri_in   = t;
        color_in = {24'h0000C3, t[0][0], 24'h00005A};
        box_in   = {24'(ury), 24'(urx), 24'(lly), 24'(llx)};
        sub_in   = sub;
        valid_in = 1'b1;
        tick();
        if (!hold) valid_in = 1'b0;
    endtask

    // Check the sample on show now, then advance one clock.
    task automatic expect_samp(input string tag, input int x, input int y);
        check({tag, " valid"}, valid_out, 1'b1);
        check({tag, " halt"}, halt, 1'b0);
        check({tag, " xy"}, sample, {24'(y), 24'(x)});
        tick();
    endtask

    task automatic expect_idle(input string tag);
        check({tag, " valid"}, valid_out, 1'b0);
        check({tag, " halt"}, halt, 1'b1);
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        ta       = {9{24'h00000A}};
        tb       = {9{24'h00000B}};
        tc       = {9{24'h00000C}};
        td       = {9{24'h00000D}};
        rst      = 1'b0;
        tri_in   = td;
        color_in = '1;
        box_in   = '0;
        valid_in = 1'b0;
        sub_in   = 4'b1000;
        #2;
        check("rst valid", valid_out, 1'b0);
        check("rst halt", halt, 1'b1);
        check("rst sample", sample, 48'h0);
        check("rst tri", tri_out, 216'h0);
        check("rst color", color_out, 72'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();
        expect_idle("idle0");

        // 3x2 walk at one pixel per step
        send(ta, 0, 0, 2048, 1024, 4'b1000, 1'b0);
        check("t1 color", color_out, {24'h0000C3, 24'h00000A, 24'h00005A});
        expect_samp("t1 s0", 0, 0);
        expect_samp("t1 s1", 1024, 0);
        expect_samp("t1 s2", 2048, 0);
        expect_samp("t1 s3", 0, 1024);
        expect_samp("t1 s4", 1024, 1024);
        expect_samp("t1 s5", 2048, 1024);
        expect_idle("t1 end");

        // half-pixel step; step input changes mid-walk are ignored
        send(tb, 0, 0, 512, 512, 4'b0100, 1'b0);
        sub_in = 4'b0001;
        expect_samp("t2 s0", 0, 0);
        expect_samp("t2 s1", 512, 0);
        expect_samp("t2 s2", 0, 512);
        expect_samp("t2 s3", 512, 512);
        expect_idle("t2 end");

        // degenerate box followed by a triangle already held valid
        send(ta, 5120, 3072, 5120, 3072, 4'b1000, 1'b1);
        tri_in = tb;
        box_in = {24'(0), 24'(1024), 24'(0), 24'(0)};
        check("t3 triA", tri_out, ta);
        expect_samp("t3 a0", 5120, 3072);
        expect_idle("t3 gap");
        check("t3 gap tri", tri_out, ta);
        tick();
        valid_in = 1'b0;
        check("t3 triB", tri_out, tb);
        expect_samp("t3 b0", 0, 0);
        expect_samp("t3 b1", 1024, 0);
        expect_idle("t3 end");

        // negative coordinates exercise the signed compares
        send(tc, -1024, -1024, 0, 0, 4'b1000, 1'b0);
        expect_samp("t4 s0", -1024, -1024);
        expect_samp("t4 s1", 0, -1024);
        expect_samp("t4 s2", -1024, 0);
        expect_samp("t4 s3", 0, 0);
        expect_idle("t4 end");

        send(tc, 2048, 0, 0, 0, 4'b1000, 1'b0);
        expect_samp("inv x", 2048, 0);
        expect_idle("inv x end");
        send(tc, 0, 2048, 2048, 0, 4'b1000, 1'b0);
        expect_samp("inv y", 0, 2048);
        expect_idle("inv y end");

        // reset on the third sample of a six-sample box
        send(ta, 0, 0, 2048, 1024, 4'b1000, 1'b0);
        expect_samp("t5 s0", 0, 0);
        expect_samp("t5 s1", 1024, 0);
        check("t5 s2 xy", sample, {24'(0), 24'(2048)});
        rst = 1'b0;
        #2;
        check("t5 rst valid", valid_out, 1'b0);
        check("t5 rst halt", halt, 1'b1);
        check("t5 rst sample", sample, 48'h0);
        #2;
        rst = 1'b1;
        tick();
        expect_idle("t5 after");
        send(tb, 1024, 1024, 1024, 1024, 4'b1000, 1'b0);
        check("t5 new tri", tri_out, tb);
        expect_samp("t5 new", 1024, 1024);
        expect_idle("t5 end");

        // upstream activity during TEST must not disturb the walk
        send(tc, 0, 0, 1024, 1024, 4'b1000, 1'b0);
        tri_in = td;
        box_in = {24'(4096), 24'(4096), 24'(3072), 24'(3072)};
        for (int i = 0; i < 4; i++) begin
            valid_in = (i % 2 == 0) && (i < 3);
            check("t6 tri", tri_out, tc);
            expect_samp("t6 s", (i % 2) * 1024, (i / 2) * 1024);
        end
        valid_in = 1'b0;
        expect_idle("t6 end");
        check("t6 tri end", tri_out, tc);
        tick();
        expect_idle("t6 idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
